// File: rtl/move_sequencer.sv
// Hardwired fetch/execute sequencer for the simple-cpu datapath (mfhi/mflo class).
// Optional memory-read timeout: define MEM_TIMEOUT_EN to fault after MEM_TIMEOUT stalled T1 cycles.
module move_sequencer #(
  parameter int unsigned      IR_W        = 32,
  parameter int unsigned      OPC_W       = 5,
  parameter logic [OPC_W-1:0] MFHI_OPC    = 5'b11001,
  parameter logic [OPC_W-1:0] MFLO_OPC    = 5'b11010,
  parameter logic [OPC_W-1:0] HALT_OPC    = 5'b11011,
  parameter int unsigned      COUNT_W     = 16,
  parameter int unsigned      MEM_TIMEOUT = 15
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Run,
  input  logic               Mem_ready,
  input  logic [IR_W-1:0]    IR_in,
  output logic               PCout,
  output logic               MARin,
  output logic               IncPC,
  output logic               Zin,
  output logic               Zlowout,
  output logic               PCin,
  output logic               Read,
  output logic               MDRin,
  output logic               MDRout,
  output logic               IRin,
  output logic               GRA,
  output logic               Rin,
  output logic               HIout,
  output logic               LOout,
  output logic [2:0]         Step,
  output logic               Halted,
  output logic               Fault,
  output logic [COUNT_W-1:0] Instr_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_T0    = 3'd1,
    S_T1    = 3'd2,
    S_T2    = 3'd3,
    S_T3    = 3'd4,
    S_HALT  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_t1_first;
  logic               w_retire;
  logic [COUNT_W-1:0] r_count;
  logic [OPC_W-1:0]   w_opc;
  logic               w_ir_unused;
  logic               w_timeout;

  assign w_opc       = IR_in[IR_W-1 -: OPC_W];
  assign w_ir_unused = ^IR_in[IR_W-OPC_W-1:0];

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;
  logic [WAIT_W-1:0] r_wait;

  // Fires on the stalled T1 cycle that would make the wait count reach the limit.
  assign w_timeout = (r_state == S_T1) && !Mem_ready && (r_wait == WAIT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wait <= '0;
    end else if (r_state != S_T1) begin
      r_wait <= '0;
    end else if (!Mem_ready) begin
      r_wait <= r_wait + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= S_IDLE;
      r_t1_first <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_next;
      r_t1_first <= (w_next == S_T1) && (r_state != S_T1);
      if (w_retire) r_count <= r_count + 1'b1;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    GRA      = 1'b0;
    Rin      = 1'b0;
    HIout    = 1'b0;
    LOout    = 1'b0;
    case (r_state)
      S_IDLE: if (Run) w_next = S_T0;
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zin    = 1'b1;
        w_next = S_T1;
      end
      S_T1: begin
        // PC is loaded from Z only once, however long memory stalls.
        Zlowout = r_t1_first;
        PCin    = r_t1_first;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (Mem_ready)      w_next = S_T2;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        w_next = S_T3;
      end
      S_T3: begin
        if (w_opc == MFHI_OPC || w_opc == MFLO_OPC) begin
          GRA      = 1'b1;
          Rin      = 1'b1;
          HIout    = (w_opc == MFHI_OPC);
          LOout    = (w_opc == MFLO_OPC);
          w_retire = 1'b1;
          w_next   = Run ? S_T0 : S_IDLE;
        end else if (w_opc == HALT_OPC) begin
          w_next = S_HALT;
        end else begin
          w_next = S_FAULT;
        end
      end
      S_HALT:  w_next = S_HALT;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_IDLE;
    endcase
  end

  assign Step        = r_state;
  assign Halted      = (r_state == S_HALT);
  assign Fault       = (r_state == S_FAULT);
  assign Instr_count = r_count;

endmodule

// File: tb/tb_move_sequencer.sv
// Randomised instruction-level bench for move_sequencer; expected per-cycle outputs are planned from each instruction's shape.
module tb_move_sequencer;

  localparam int unsigned IR_W        = 32;
  localparam int unsigned COUNT_W     = 2;
  localparam int unsigned MEM_TIMEOUT = 15;
  localparam logic [4:0]  MFHI        = 5'b11001;
  localparam logic [4:0]  MFLO        = 5'b11010;
  localparam logic [4:0]  HALT        = 5'b11011;

  // {PCout,MARin,IncPC,Zin, Zlowout,PCin,Read,MDRin, MDRout,IRin, GRA,Rin,HIout,LOout}
  localparam logic [13:0] X_NONE = 14'b0000_0000_00_0000;
  localparam logic [13:0] X_T0   = 14'b1111_0000_00_0000;
  localparam logic [13:0] X_T1F  = 14'b0000_1111_00_0000;
  localparam logic [13:0] X_T1W  = 14'b0000_0011_00_0000;
  localparam logic [13:0] X_T2   = 14'b0000_0000_11_0000;
  localparam logic [13:0] X_HI   = 14'b0000_0000_00_1110;
  localparam logic [13:0] X_LO   = 14'b0000_0000_00_1101;

  logic               Clock = 1'b0;
  logic               Reset_n;
  logic               Run;
  logic               Mem_ready;
  logic [IR_W-1:0]    IR_in;
  logic               PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin;
  logic               MDRout, IRin, GRA, Rin, HIout, LOout;
  logic [2:0]         Step;
  logic               Halted, Fault;
  logic [COUNT_W-1:0] Instr_count;

  move_sequencer #(
    .IR_W(IR_W), .COUNT_W(COUNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Run(Run), .Mem_ready(Mem_ready), .IR_in(IR_in),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
    .Zlowout(Zlowout), .PCin(PCin), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .GRA(GRA), .Rin(Rin), .HIout(HIout), .LOout(LOout),
    .Step(Step), .Halted(Halted), .Fault(Fault), .Instr_count(Instr_count)
  );

  always #5 Clock = ~Clock;

  wire [13:0] w_strb = {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
                        MDRout, IRin, GRA, Rin, HIout, LOout};

  typedef struct packed {
    logic [2:0]         step;
    logic [13:0]        strb;
    logic [COUNT_W-1:0] cnt;
  } exp_t;

  exp_t               q[$];
  int                 n_tests = 0;
  int                 n_fail  = 0;
  logic [COUNT_W-1:0] m_cnt   = '0;
  bit                 at_t0   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("step",    32'(Step),        32'(e.step));
      chk("strobes", 32'(w_strb),      32'(e.strb));
      chk("halted",  32'(Halted),      32'(e.step == 3'd5));
      chk("fault",   32'(Fault),       32'(e.step == 3'd6));
      chk("count",   32'(Instr_count), 32'(e.cnt));
    end
  end

  // One clock: drive this cycle's inputs and record what the outputs must be during it.
  task automatic cyc(input logic run, input logic mr, input logic [IR_W-1:0] ir,
                     input logic [2:0] step, input logic [13:0] strb);
    exp_t e;
    @(posedge Clock);
    #1;
    Run       = run;
    Mem_ready = mr;
    IR_in     = ir;
    e.step = step;
    e.strb = strb;
    e.cnt  = m_cnt;
    q.push_back(e);
  endtask

  task automatic idle();
    cyc(1'b0, 1'($urandom), $urandom, 3'd0, X_NONE);
  endtask

  task automatic sticky(input logic [2:0] step);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'($urandom), $urandom, step, X_NONE);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    #1;
    Reset_n   = 1'b0;
    Run       = 1'b0;
    Mem_ready = 1'b0;
    #1;
    chk("rst_async_step",   32'(Step),        32'd0);
    chk("rst_async_strobe", 32'(w_strb),      32'd0);
    chk("rst_async_count",  32'(Instr_count), 32'd0);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    #1;
    chk("rst_held_step",  32'(Step),            32'd0);
    chk("rst_held_flags", 32'({Halted, Fault}), 32'd0);
    Reset_n = 1'b1;
    m_cnt   = '0;
    at_t0   = 1'b0;
  endtask

  // Plans one instruction from its opcode, number of stalled T1 cycles and Run at T3.
  task automatic run_instr(input logic [4:0] opc, input int waits, input logic run_exit);
    logic [IR_W-1:0] ir;
    if (!at_t0) cyc(1'b1, 1'($urandom), $urandom, 3'd0, X_NONE);
    cyc(1'($urandom), 1'($urandom), $urandom, 3'd1, X_T0);
    for (int k = 0; k <= waits; k++) begin
      cyc(1'($urandom), (k == waits), $urandom, 3'd2, (k == 0) ? X_T1F : X_T1W);
`ifdef MEM_TIMEOUT_EN
      if (k < waits && k == int'(MEM_TIMEOUT) - 1) begin
        sticky(3'd6);
        return;
      end
`endif
    end
    cyc(1'($urandom), 1'($urandom), $urandom, 3'd3, X_T2);
    ir = $urandom;
    ir[IR_W-1 -: 5] = opc;
    if (opc == MFHI || opc == MFLO) begin
      cyc(run_exit, 1'($urandom), ir, 3'd4, (opc == MFHI) ? X_HI : X_LO);
      m_cnt = m_cnt + 1'b1;
      at_t0 = run_exit;
    end else begin
      cyc(run_exit, 1'($urandom), ir, 3'd4, X_NONE);
      sticky((opc == HALT) ? 3'd5 : 3'd6);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset_n   = 1'b0;
    Run       = 1'b0;
    Mem_ready = 1'b0;
    IR_in     = '0;
    do_reset();
    repeat (5) idle();

    run_instr(MFHI, 0, 1'b0);
    idle();
    chk("lit_count_one", 32'(Instr_count), 32'd1);
    chk("lit_idle_step", 32'(Step), 32'd0);

    run_instr(MFLO, 3, 1'b0);
    idle();
    chk("lit_count_two", 32'(Instr_count), 32'd2);

    do_reset();
    for (int i = 0; i < 5; i++) run_instr(MFHI, 0, (i < 4));
    idle();
    chk("lit_count_wrap", 32'(Instr_count), 32'd1);

    repeat (40) begin
      run_instr($urandom_range(0, 1) ? MFHI : MFLO, $urandom_range(0, 4), 1'($urandom));
      if (!at_t0) repeat ($urandom_range(0, 2)) idle();
    end
    if (at_t0) run_instr(MFLO, 0, 1'b0);
    run_instr(MFHI, 20, 1'b0);
    do_reset();

    run_instr(HALT, 1, 1'b1);
    chk("lit_halted", 32'({Halted, Fault}), 32'b10);
    do_reset();

    run_instr(5'b00000, 0, 1'b0);
    chk("lit_fault", 32'({Halted, Fault}), 32'b01);
    do_reset();

    repeat (4) begin
      run_instr(5'($urandom_range(0, 24)), $urandom_range(0, 2), 1'($urandom));
      do_reset();
    end

    cyc(1'b1, 1'b0, $urandom, 3'd0, X_NONE);
    cyc(1'b0, 1'b0, $urandom, 3'd1, X_T0);
    cyc(1'b0, 1'b0, $urandom, 3'd2, X_T1F);
    cyc(1'b0, 1'b0, $urandom, 3'd2, X_T1W);
    do_reset();
    repeat (2) idle();

`ifdef MEM_TIMEOUT_EN
    run_instr(MFHI, int'(MEM_TIMEOUT) - 1, 1'b0);
    idle();
    chk("lit_ready_at_limit", 32'(Instr_count), 32'd1);
    run_instr(MFLO, 30, 1'b0);
    chk("lit_timeout_fault", 32'(Fault), 32'd1);
    do_reset();
`endif

    @(posedge Clock);
    @(negedge Clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
